// File: rtl/hwpe_sel_arbiter.sv
// Round-robin owner arbiter for the shared HWPE slot: gates hwpe_en_o while the select changes.
// Optional idle-owner watchdog is built when HWPE_SEL_ARBITER_WATCHDOG_EN is defined.
module hwpe_sel_arbiter #(
  parameter int unsigned N_CORES        = 8,
  parameter int unsigned NUM_HWPES      = 2,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned SWITCH_GAP     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned OW = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CORES-1:0]              req_i,
  input  logic [N_CORES-1:0][SEL_W-1:0]   sel_req_i,
  output logic [N_CORES-1:0]              gnt_o,
  output logic [N_CORES-1:0]              err_o,
  output logic [N_CORES-1:0]              timeout_o,
  input  logic                            hwpe_busy_i,
  output logic                            hwpe_en_o,
  output logic [SEL_W-1:0]                hwpe_sel_o,
  output logic                            owner_valid_o,
  output logic [OW-1:0]                   owner_o
);

  localparam int unsigned GW = $clog2(SWITCH_GAP + 1);

  if (SWITCH_GAP < 1 || SWITCH_GAP > 15) begin : g_bad_gap
    $error("SWITCH_GAP must be within 1..15");
  end
  if (NUM_HWPES < 1 || NUM_HWPES > (1 << SEL_W)) begin : g_bad_hwpes
    $error("NUM_HWPES must be within 1..2**SEL_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SWITCH, OWNED, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N_CORES-1:0]   mask_q, mask_d, mask_set;
  logic [N_CORES-1:0]   gnt_q, gnt_d;
  logic [N_CORES-1:0]   err_q, err_d;
  logic                 en_q, en_d;
  logic                 ov_q, ov_d;

  logic [N_CORES-1:0]   elig;
  logic                 win_found;
  logic [OW-1:0]        win_idx;
  logic [OW-1:0]        ptr_nxt;

`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0]        wd_q, wd_d;
  logic [N_CORES-1:0]   tmo_q, tmo_d;
  logic                 wd_expire;

  assign wd_expire = !hwpe_busy_i && (wd_q == WW'(TIMEOUT_CYCLES - 1));
`endif

  assign elig = req_i & ~mask_q;

  // Scan starts at the pointer and wraps, so the last winner is searched last.
  always_comb begin : arb
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!win_found && elig[idx[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[OW-1:0];
      end
    end
    ptr_nxt = (win_idx == OW'(N_CORES - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin : fsm
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    sel_d    = sel_q;
    gap_d    = gap_q;
    mask_set = '0;
    err_d    = '0;
`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
    tmo_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d = ptr_nxt;
          if (32'(sel_req_i[win_idx]) >= NUM_HWPES) begin
            err_d[win_idx]    = 1'b1;
            mask_set[win_idx] = 1'b1;
          end else begin
            owner_d = win_idx;
            if (sel_req_i[win_idx] == sel_q) begin
              state_d = OWNED;
            end else begin
              sel_d   = sel_req_i[win_idx];
              gap_d   = '0;
              state_d = SWITCH;
            end
          end
        end
      end
      SWITCH: begin
        if (!req_i[owner_q])                      state_d = IDLE;
        else if (gap_q == GW'(SWITCH_GAP - 1))    state_d = OWNED;
        else                                      gap_d   = gap_q + 1'b1;
      end
      OWNED: begin
        if (!req_i[owner_q]) begin
          state_d = hwpe_busy_i ? DRAIN : IDLE;
        end
`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
        else if (wd_expire) begin
          state_d           = IDLE;
          mask_set[owner_q] = 1'b1;
          tmo_d[owner_q]    = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (!hwpe_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mask_d = (mask_q | mask_set) & req_i;

    // Outputs follow the current state but already reflect a departure decided this cycle,
    // so enable falls together with entry to IDLE and a later select change sees it low.
    ov_d  = (state_q == OWNED) && (state_d == OWNED);
    gnt_d = '0;
    if (ov_d) gnt_d[owner_q] = 1'b1;
    en_d  = (state_q inside {OWNED, DRAIN}) && (state_d inside {OWNED, DRAIN});
  end

`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
  always_comb begin : wdog
    wd_d = '0;
    if (state_q == OWNED && state_d == OWNED && !hwpe_busy_i) wd_d = wd_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      sel_q   <= '0;
      gap_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
      wd_q    <= '0;
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      en_q    <= en_d;
      ov_q    <= ov_d;
`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gnt_o         = gnt_q;
  assign err_o         = err_q;
  assign hwpe_en_o     = en_q;
  assign hwpe_sel_o    = sel_q;
  assign owner_valid_o = ov_q;
  assign owner_o       = owner_q;
`ifdef HWPE_SEL_ARBITER_WATCHDOG_EN
  assign timeout_o     = tmo_q;
`else
  assign timeout_o     = '0;
`endif

endmodule

// File: doc/hwpe_sel_arbiter.md
Name: hwpe_sel_arbiter

Overview:
- Sequencer and arbiter for the cluster HWPE subsystem.
- Shares the single selectable HWPE slot between N_CORES requesting cores, one owner at a time.
- Drives hwpe_en/hwpe_sel of the HWPE subsystem, switches selection only while the HWPE clock is gated and the engine is idle, and returns an ownership grant to each core.
- Sits between the cluster peripheral control registers and the HWPE subsystem.

Parameters:
- N_CORES, 8, number of requesting cores.
- NUM_HWPES, 2, number of instantiated HWPEs; valid select values are 0..NUM_HWPES-1.
- SEL_W, 2, width of select fields; fixed at $clog2(MAX_NUM_HWPES).
- SWITCH_GAP, 2, cycles hwpe_en_o is held low after hwpe_sel_o changes; 1..15.
- TIMEOUT_CYCLES, 1024, idle-owner watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  cluster clock.
- rst  in  1  synchronous reset, active-high.
- req_i  in  N_CORES  per-core ownership request, level; held for the duration of ownership.
- sel_req_i  in  N_CORES x SEL_W  requested HWPE index per core; sampled at the arbitration win.
- gnt_o  out  N_CORES  ownership grant, level, one-hot or zero.
- err_o  out  N_CORES  one-cycle pulse: request rejected for an invalid index.
- timeout_o  out  N_CORES  one-cycle pulse: ownership revoked by the watchdog.
- hwpe_busy_i  in  1  busy of the currently selected HWPE.
- hwpe_en_o  out  1  HWPE enable; drives the clock gate.
- hwpe_sel_o  out  SEL_W  selected HWPE.
- owner_valid_o  out  1  an owner exists (state OWNED).
- owner_o  out  $clog2(N_CORES)  current or most recent owner index.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; gnt_o=0, err_o=0, timeout_o=0, hwpe_en_o=0, hwpe_sel_o=0, owner_valid_o=0, owner_o=0, round-robin pointer=0, gap counter=0, watchdog=0, mask=0.
- Reset mid-operation: all outputs return to reset values at the same edge. hwpe_en_o drops immediately.
- Every output is registered.
- States: IDLE, SWITCH, OWNED, DRAIN.
- IDLE:
  - hwpe_en_o=0.
  - If any unmasked req_i is high, pick winner w by round-robin, starting from the pointer (pointer = last winner+1 mod N_CORES).
  - If sel_req_i[w] >= NUM_HWPES: err_o[w] pulses next cycle, pointer advances past w, w is masked, state stays IDLE.
  - Else, latch sel, owner_o=w. If latched sel == hwpe_sel_o, go to OWNED; otherwise hwpe_sel_o=sel and go to SWITCH.
- SWITCH:
  - hwpe_en_o=0; counter counts SWITCH_GAP cycles, then go to OWNED.
  - A req_i[w] drop during SWITCH aborts to IDLE; no grant is issued.
- OWNED:
  - hwpe_en_o=1, gnt_o[w]=1, owner_valid_o=1.
  - hwpe_sel_o is frozen; sel_req_i changes are ignored.
  - On req_i[w]=0: gnt_o drops next cycle. Go to DRAIN if hwpe_busy_i=1, else IDLE.
- DRAIN: hwpe_en_o=1, gnt_o=0; stay until hwpe_busy_i=0, then go to IDLE (hwpe_en_o=0 next cycle).
- Latency: req with unchanged sel gives gnt_o 2 cycles after req rises (arbitrate, then grant). With changed sel: 2+SWITCH_GAP cycles.
- hwpe_sel_o changes only on an IDLE->SWITCH edge, when hwpe_en_o is already 0.
- Requests from non-owners while the slot is held are ignored until IDLE. No request is lost, because req is level.
- Mask: a core's mask bit is set by err/timeout and cleared when its req_i goes low. Masked requests are not arbitrated.
- Simultaneous release and new requests: the slot passes through DRAIN/IDLE. There is no direct owner-to-owner handoff.

Optional Feature:
- Macro: HWPE_SEL_ARBITER_WATCHDOG_EN.
- Defined:
  - In OWNED, a counter increments on each cycle with hwpe_busy_i=0 and resets on busy=1.
  - On reaching TIMEOUT_CYCLES: gnt_o[w] drops, timeout_o[w] pulses, w is masked, state goes to IDLE.
  - The counter clears on entry to OWNED.
- Undefined: no counter is built, timeout_o is tied 0, and TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset, then req_i[3]=1 with sel_req_i[3]=0 -> gnt_o[3]=1 at cycle 2, hwpe_en_o=1, hwpe_sel_o=0, no SWITCH gap.
- Core 3 owns HWPE 0 and releases; then core 5 requests sel 1 with SWITCH_GAP=2 -> hwpe_sel_o=1 while en=0 for 2 cycles, gnt_o[5] at cycle 4, hwpe_en_o never high while sel changes.
- Owner drops req while hwpe_busy_i=1 for 10 cycles -> gnt_o=0 next cycle, hwpe_en_o stays 1 for 10 cycles (DRAIN), then 0. A pending core 1 is granted only afterwards.
- Cores 0, 1, 2 request continuously, each releasing after 4 cycles -> grant order 0, 1, 2, 0, with no core granted twice in a row.
- Core 2 requests sel=3 with NUM_HWPES=2 -> err_o[2] pulses once, no grant, no re-error until req_i[2] toggles low then high.
- With HWPE_SEL_ARBITER_WATCHDOG_EN and TIMEOUT_CYCLES=16: owner idle with busy=0 for 16 cycles -> timeout_o pulse, gnt drop, IDLE. Without the macro, the same stimulus keeps gnt_o high indefinitely.
